// File: rtl/led_matrix_pkg.sv
// Shared types and helpers for the LED matrix datapath.
// Holds the pixel loader FSM encoding and address-width math.
package led_matrix_pkg;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      COMMIT
   } state_t;

   // Framebuffer address = {section, row, column}.
   function automatic int addr_width(
      input int sections,
      input int row_bits,
      input int col_bits
   );
      return $clog2(sections) + row_bits + col_bits;
   endfunction

endpackage

// File: rtl/pixel_loader.sv
// Fetches one pixel column for every panel section from the framebuffer.
// Ports: clk_in/reset; start + row/column request; ram_addr/ram_en/ram_rdata
// framebuffer read port; pixel_out (section 0 in LSBs), busy, done, overrun.
module pixel_loader
   import led_matrix_pkg::*;
#(
   parameter int SECTIONS    = 2,
   parameter int ROW_BITS    = 4,
   parameter int COL_BITS    = 6,
   parameter int PIXEL_WIDTH = 16,
   parameter int RAM_LATENCY = 2,
   parameter int COL_REVERSE = 1
) (
   input  logic                                           clk_in,
   input  logic                                           reset,
   input  logic                                           start,
   input  logic [ROW_BITS-1:0]                            row_address,
   input  logic [COL_BITS-1:0]                            column_address,
   output logic [addr_width(SECTIONS,ROW_BITS,COL_BITS)-1:0] ram_addr,
   output logic                                           ram_en,
   input  logic [PIXEL_WIDTH-1:0]                         ram_rdata,
   output logic [SECTIONS*PIXEL_WIDTH-1:0]                pixel_out,
   output logic                                           busy,
   output logic                                           done,
   output logic                                           overrun
);

   localparam int AW = addr_width(SECTIONS, ROW_BITS, COL_BITS);
   localparam int SB = $clog2(SECTIONS);
   localparam int LW = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;
   localparam int PW = SECTIONS * PIXEL_WIDTH;

   localparam logic [SB-1:0] LAST_SEC = SB'(SECTIONS - 1);
   localparam logic [LW-1:0] LAST_LAT = LW'(RAM_LATENCY - 1);

   function automatic logic [AW-1:0] make_addr(
      input logic [SB-1:0]       s,
      input logic [ROW_BITS-1:0] r,
      input logic [COL_BITS-1:0] c
   );
      return {s, r, (COL_REVERSE != 0) ? ~c : c};
   endfunction

   state_t              state_q, state_d;
   logic [ROW_BITS-1:0] row_q, row_d;
   logic [COL_BITS-1:0] col_q, col_d;
   logic [SB-1:0]       sec_q, sec_d;
   logic [LW-1:0]       lat_q, lat_d;
   logic [PW-1:0]       shadow_q, shadow_d;
   logic [PW-1:0]       pix_d;
   logic [AW-1:0]       addr_d;
   logic                en_d, busy_d, done_d, ovr_d;

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         row_q     <= '0;
         col_q     <= '0;
         sec_q     <= '0;
         lat_q     <= '0;
         shadow_q  <= '0;
         pixel_out <= '0;
         ram_addr  <= '0;
         ram_en    <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         state_q   <= state_d;
         row_q     <= row_d;
         col_q     <= col_d;
         sec_q     <= sec_d;
         lat_q     <= lat_d;
         shadow_q  <= shadow_d;
         pixel_out <= pix_d;
         ram_addr  <= addr_d;
         ram_en    <= en_d;
         busy      <= busy_d;
         done      <= done_d;
         overrun   <= ovr_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      row_d    = row_q;
      col_d    = col_q;
      sec_d    = sec_q;
      lat_d    = lat_q;
      shadow_d = shadow_q;
      pix_d    = pixel_out;
      addr_d   = ram_addr;
      en_d     = ram_en;
      busy_d   = busy;
      done_d   = 1'b0;
      ovr_d    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               row_d   = row_address;
               col_d   = column_address;
               sec_d   = '0;
               lat_d   = '0;
               addr_d  = make_addr('0, row_address, column_address);
               en_d    = 1'b1;
               busy_d  = 1'b1;
               state_d = FETCH;
            end
         end
         FETCH: begin
            ovr_d = start;
            if (lat_q == LAST_LAT) begin
               lat_d = '0;
               shadow_d[sec_q*PIXEL_WIDTH +: PIXEL_WIDTH] = ram_rdata;
               // Stop on the last section so the index never wraps.
               if (sec_q == LAST_SEC) begin
                  en_d    = 1'b0;
                  state_d = COMMIT;
               end else begin
                  sec_d  = sec_q + 1'b1;
                  addr_d = make_addr(sec_q + 1'b1, row_q, col_q);
               end
            end else begin
               lat_d = lat_q + 1'b1;
            end
         end
         COMMIT: begin
            ovr_d   = start;
            pix_d   = shadow_q;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_pixel_loader.sv
// Directed bench for pixel_loader: default build plus a 4-section build.
// Checks addressing, latency, commit, overrun and reset abort.
module tb_pixel_loader;

   logic        clk_in = 1'b0;
   logic        reset  = 1'b1;
   logic        start  = 1'b0;
   logic [3:0]  row    = '0;
   logic [5:0]  col    = '0;
   logic [10:0] ram_addr;
   logic        ram_en;
   logic [15:0] ram_rdata;
   logic [31:0] pixel_out;
   logic        busy, done, overrun;

   logic        start4 = 1'b0;
   logic [3:0]  row4   = '0;
   logic [5:0]  col4   = '0;
   logic [11:0] ram_addr4;
   logic        ram_en4;
   logic [15:0] ram_rdata4;
   logic [63:0] pixel_out4;
   logic        busy4, done4, overrun4;

   int checks = 0;
   int errors = 0;

   logic [15:0] mem0 = '0;
   logic [15:0] mem1 = '0;
   logic [15:0] pipe1;
   logic [31:0] cur_pix = '0;

   typedef struct {
      logic [3:0]  row;
      logic [5:0]  col;
      logic [15:0] d0;
      logic [15:0] d1;
      logic [10:0] a0;
      logic [10:0] a1;
      logic [31:0] pix;
   } vec_t;

   vec_t vecs[4];

   always #5 clk_in = ~clk_in;

   // Two-cycle RAM model for the default build.
   always_ff @(posedge clk_in) pipe1 <= ram_addr[10] ? mem1 : mem0;
   assign ram_rdata = pipe1;

   // Single-cycle RAM model for the 4-section build.
   assign ram_rdata4 = {4'hB, ram_addr4};

   pixel_loader dut (
      .clk_in(clk_in), .reset(reset), .start(start),
      .row_address(row), .column_address(col),
      .ram_addr(ram_addr), .ram_en(ram_en), .ram_rdata(ram_rdata),
      .pixel_out(pixel_out), .busy(busy), .done(done), .overrun(overrun)
   );

   pixel_loader #(
      .SECTIONS(4), .RAM_LATENCY(1), .COL_REVERSE(0)
   ) dut4 (
      .clk_in(clk_in), .reset(reset), .start(start4),
      .row_address(row4), .column_address(col4),
      .ram_addr(ram_addr4), .ram_en(ram_en4), .ram_rdata(ram_rdata4),
      .pixel_out(pixel_out4), .busy(busy4), .done(done4),
      .overrun(overrun4)
   );

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h want=%h @%0t", name, act, exp, $time);
      end
   endtask

   task automatic run_vec(input vec_t v);
      logic [31:0] prev;
      prev  = cur_pix;
      mem0  = v.d0;
      mem1  = v.d1;
      row   = v.row;
      col   = v.col;
      start = 1'b1;
      step();
      start = 1'b0;
      row   = ~v.row;
      col   = ~v.col;
      for (int k = 0; k < 7; k++) begin
         if (k > 0) step();
         if (k < 4) chk("addr", 64'(ram_addr), 64'((k < 2) ? v.a0 : v.a1));
         chk("en", 64'(ram_en), 64'(k < 4));
         chk("busy", 64'(busy), 64'(k < 5));
         chk("done", 64'(done), 64'(k == 5));
         chk("ovr", 64'(overrun), 64'd0);
         chk("pix", 64'(pixel_out), 64'((k < 5) ? prev : v.pix));
      end
      cur_pix = v.pix;
   endtask

   initial begin
      int ndone;
      vecs[0] = '{4'h3, 6'h05, 16'hF800, 16'h07E0, 11'h0FA, 11'h4FA, 32'h07E0_F800};
      vecs[1] = '{4'h0, 6'h00, 16'h1234, 16'hABCD, 11'h03F, 11'h43F, 32'hABCD_1234};
      vecs[2] = '{4'hF, 6'h3F, 16'hFFFF, 16'h0000, 11'h3C0, 11'h7C0, 32'h0000_FFFF};
      vecs[3] = '{4'hA, 6'h2A, 16'h5A5A, 16'hA5A5, 11'h295, 11'h695, 32'hA5A5_5A5A};

      repeat (2) @(posedge clk_in);
      #1;
      chk("rst_addr", 64'(ram_addr), 64'd0);
      chk("rst_en", 64'(ram_en), 64'd0);
      chk("rst_pix", 64'(pixel_out), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_ovr", 64'(overrun), 64'd0);
      chk("rst_pix4", pixel_out4, 64'd0);
      reset = 1'b0;
      step();

      for (int i = 0; i < 4; i++) begin
         run_vec(vecs[i]);
         step();
      end

      // start re-sampled two cycles into the fetch.
      mem0  = 16'hF800;
      mem1  = 16'h07E0;
      row   = 4'h3;
      col   = 6'h05;
      ndone = 0;
      for (int k = 0; k < 8; k++) begin
         start = (k == 0) || (k == 2);
         step();
         start = 1'b0;
         chk("ovr_seq", 64'(overrun), 64'(k == 2));
         chk("ovr_done", 64'(done), 64'(k == 5));
         if (done) ndone++;
      end
      chk("ovr_pix", 64'(pixel_out), 64'h07E0_F800);
      chk("ovr_ndone", 64'(ndone), 64'd1);
      cur_pix = 32'h07E0_F800;

      // Reset three cycles into a fetch.
      mem0  = 16'h1234;
      mem1  = 16'hABCD;
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (3) step();
      reset = 1'b1;
      #1;
      chk("ab_addr", 64'(ram_addr), 64'd0);
      chk("ab_en", 64'(ram_en), 64'd0);
      chk("ab_pix", 64'(pixel_out), 64'd0);
      chk("ab_busy", 64'(busy), 64'd0);
      chk("ab_done", 64'(done), 64'd0);
      step();
      chk("ab_done2", 64'(done), 64'd0);
      reset = 1'b0;
      cur_pix = '0;
      step();
      run_vec(vecs[0]);
      step();

      // Four sections, single-cycle RAM, no column reversal.
      row4   = 4'h0;
      col4   = 6'h01;
      start4 = 1'b1;
      step();
      start4 = 1'b0;
      for (int k = 0; k < 7; k++) begin
         if (k > 0) step();
         if (k < 4) chk("addr4", 64'(ram_addr4), 64'(12'h001 | (k << 10)));
         chk("en4", 64'(ram_en4), 64'(k < 4));
         chk("done4", 64'(done4), 64'(k == 5));
         if (k == 5) chk("pix4", pixel_out4, 64'hBC01_B801_B401_B001);
      end

      // start held high for 20 sampling edges.
      mem0  = 16'h0F0F;
      mem1  = 16'hF0F0;
      start = 1'b1;
      for (int k = 0; k < 26; k++) begin
         step();
         if (k == 19) start = 1'b0;
         chk("held_done", 64'(done), 64'((k % 6 == 5) && (k <= 23)));
         chk("held_ovr", 64'(overrun), 64'((k < 20) && (k % 6 != 0)));
      end
      chk("held_pix", 64'(pixel_out), 64'hF0F0_0F0F);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pixel_loader.md
PIXEL_LOADER -- requirements
Module: pixel_loader

Interface
REQ-001 SECTIONS, 2, number of panel sections fetched per pixel; power of two, 2..8.
REQ-002 ROW_BITS, 4, row address width.
REQ-003 COL_BITS, 6, column address width.
REQ-004 PIXEL_WIDTH, 16, framebuffer word width.
REQ-005 RAM_LATENCY, 2, cycles from ram_addr update to valid ram_rdata; minimum 1.
REQ-006 COL_REVERSE, 1, 1 = emit bitwise-inverted column in address; 0 = column as given.
REQ-007 clk_in  input  1  single clock; all state on rising edge.
REQ-008 reset  input  1  asynchronous, active-high reset.
REQ-009 start  input  1  request to fetch one pixel column for all sections.
REQ-010 row_address  input  ROW_BITS  row to fetch.
REQ-011 column_address  input  COL_BITS  column to fetch.
REQ-012 ram_addr  output  AW = log2(SECTIONS)+ROW_BITS+COL_BITS  framebuffer read address, registered.
REQ-013 ram_en  output  1  framebuffer clock enable, registered.
REQ-014 ram_rdata  input  PIXEL_WIDTH  framebuffer read data.
REQ-015 pixel_out  output  SECTIONS*PIXEL_WIDTH  fetched pixels; section 0 in LSBs.
REQ-016 busy  output  1  high while a fetch is in progress.
REQ-017 done  output  1  one-cycle pulse when pixel_out updates.
REQ-018 overrun  output  1  one-cycle pulse when start is ignored because busy.

Function
REQ-019 FSM states SHALL be IDLE, FETCH, COMMIT.
REQ-020 In IDLE with start high at an edge, the block SHALL latch row_address and column_address, load ram_addr for section 0, set ram_en and busy, and enter FETCH.
REQ-021 Address format SHALL be {section index, latched row, latched column (inverted when COL_REVERSE=1)}.
REQ-022 In FETCH a latency counter SHALL count RAM_LATENCY cycles per section; on the edge it expires, ram_rdata SHALL be captured into the shadow slot of the current section.
REQ-023 On that same capture edge ram_addr SHALL advance to the next section; after the last section the FSM SHALL enter COMMIT and drop ram_en.
REQ-024 COMMIT SHALL last one cycle: all shadow slots copied to pixel_out simultaneously, done pulsed, busy cleared, return to IDLE.
REQ-025 Latency from the edge sampling start to the edge raising done SHALL be SECTIONS*RAM_LATENCY+1 cycles (5 with defaults).
REQ-026 pixel_out SHALL hold its value between commits; no partial update is ever visible.
REQ-027 row_address/column_address changes after the start edge SHALL not affect the fetch in progress.
REQ-028 start high while busy (FETCH or COMMIT) SHALL be ignored and SHALL pulse overrun on the following cycle.
REQ-029 start held high continuously SHALL begin a new fetch on the first edge in IDLE after COMMIT, with back-to-back fetches every SECTIONS*RAM_LATENCY+2 cycles.
REQ-030 Section index SHALL never exceed SECTIONS-1; no wrap into an extra access.

Reset
REQ-031 Reset SHALL force state IDLE, ram_addr=0, ram_en=0, pixel_out=0, shadow=0, busy=0, done=0, overrun=0, counters 0.
REQ-032 Reset asserted mid-fetch SHALL abort with no done pulse and no pixel_out update; the first start after release SHALL behave as from power-up.

Structure
REQ-033 FSM state encoding and the address-width helper function SHALL live in the shared package led_matrix_pkg.
REQ-034 No sub-module SHALL be used; latency counter, section counter and shadow registers are inline.

Verification
REQ-035 Defaults, row=3, col=6'h05, start one cycle -> ram_addr 11'h0FA for 2 cycles then 11'h4FA for 2 cycles; ram_en high 4 cycles; done 5 cycles after start edge.
REQ-036 Model RAM returning 16'hF800 (sec 0) and 16'h07E0 (sec 1) -> pixel_out=32'h07E0_F800 on done, held until next commit.
REQ-037 start re-asserted 2 cycles into fetch -> overrun pulses once, fetch completes unchanged, single done.
REQ-038 Reset asserted 3 cycles into fetch -> all outputs 0 immediately, no done; next start yields correct 5-cycle fetch.
REQ-039 SECTIONS=4, RAM_LATENCY=1, COL_REVERSE=0, row=0, col=1 -> addresses 12'h001, 12'h401, 12'h801, 12'hC01 on consecutive cycles; done 5 cycles after start edge.
REQ-040 start held high 20 cycles, defaults -> done every 6 cycles, no overrun pulses other than those for start sampled during busy.
